// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem req/ack, prefetch FIFO and
// the IF_ID register pair, with stall (HLT) and branch redirect/flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        HLT,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_inst
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [31:0]     req_addr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [31:0]     fifo_pc   [FIFO_DEPTH];
  logic [31:0]     fifo_inst [FIFO_DEPTH];

  logic            deliver;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            room;
  logic [31:0]     target;
  logic [31:0]     pc_plus4;
  logic [31:0]     redirect_pc;

  assign imem_addr = req_addr;

  always_comb begin
    target      = branch_target & ~32'd3;
    pc_plus4    = fetch_pc + 32'd4;
    // Address of the next request once the current one resolves.
    redirect_pc = branch_taken ? target : fetch_pc;
    deliver     = (state == S_WAIT) && imem_ack && !branch_taken;
    bypass      = deliver && (count == '0) && !HLT;
    push        = deliver && !bypass;
    pop         = !branch_taken && !HLT && (count != '0);
    if (branch_taken) count_next = '0;
    else              count_next = count + CW'(push) - CW'(pop);
    room        = count_next < CW'(FIFO_DEPTH);
  end

  // Request FSM. imem_req is registered alongside the state so it never glitches.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= S_IDLE;
      imem_req <= 1'b0;
      req_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          fetch_pc <= redirect_pc;
          if (room) begin
            state    <= S_WAIT;
            imem_req <= 1'b1;
            req_addr <= redirect_pc;
          end
        end
        S_WAIT: begin
          if (branch_taken) begin
            fetch_pc <= target;
            if (imem_ack) req_addr <= target;
            else          state    <= S_DROP;
          end else if (imem_ack) begin
            fetch_pc <= pc_plus4;
            if (room) begin
              req_addr <= pc_plus4;
            end else begin
              state    <= S_IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        S_DROP: begin
          // req_addr stays put until the abandoned request is acked.
          fetch_pc <= redirect_pc;
          if (imem_ack) begin
            if (room) begin
              state    <= S_WAIT;
              req_addr <= redirect_pc;
            end else begin
              state    <= S_IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; count and pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= req_addr;
      fifo_inst[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      IF_ID_pc   <= RESET_PC;
      IF_ID_inst <= '0;
    end else begin
      count <= count_next;
      if (branch_taken) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        IF_ID_inst <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (!HLT) begin
          if (count != '0) begin
            IF_ID_pc   <= fifo_pc[rd_ptr];
            IF_ID_inst <= fifo_inst[rd_ptr];
          end else if (bypass) begin
            IF_ID_pc   <= req_addr;
            IF_ID_inst <= imem_rdata;
          end else begin
            IF_ID_inst <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for streaming and
// stall, then hand-written sequences for latency, branches, wrap and reset.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        HLT;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .CLK(CLK), .RSTN(RSTN), .HLT(HLT),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        hlt;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t v(input logic hlt, input logic br, input logic [31:0] tgt,
                             input logic ack, input logic [31:0] rdata,
                             input logic req, input logic [31:0] addr,
                             input logic [31:0] pc, input logic [31:0] inst);
    vec_t r;
    r.hlt = hlt; r.br = br; r.tgt = tgt; r.ack = ack; r.rdata = rdata;
    r.req = req; r.addr = addr; r.pc = pc; r.inst = inst;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic [31:0] pc, input logic [31:0] inst);
    check({tag, " req"},  {31'd0, imem_req}, {31'd0, req});
    check({tag, " addr"}, imem_addr, addr);
    check({tag, " pc"},   IF_ID_pc, pc);
    check({tag, " inst"}, IF_ID_inst, inst);
  endtask

  // Called at a falling edge: drive one cycle of inputs, return at the next falling edge.
  task automatic cyc(input logic hlt, input logic br, input logic [31:0] tgt,
                     input logic ack, input logic [31:0] rdata);
    HLT = hlt; branch_taken = br; branch_target = tgt; imem_ack = ack; imem_rdata = rdata;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    RSTN = 1'b0; HLT = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ack = 1'b0; imem_rdata = '0;

    //         hlt br tgt ack rdata          req addr         pc           inst
    tbl[0]  = v(0, 0, 0, 0, 32'h0,         0, 32'h100, 32'h100, 32'h0);
    tbl[1]  = v(0, 0, 0, 1, 32'h113,       1, 32'h100, 32'h100, 32'h0);
    tbl[2]  = v(0, 0, 0, 1, 32'h117,       1, 32'h104, 32'h100, 32'h113);
    tbl[3]  = v(1, 0, 0, 1, 32'h11B,       1, 32'h108, 32'h104, 32'h117);
    tbl[4]  = v(1, 0, 0, 1, 32'h11F,       1, 32'h10C, 32'h104, 32'h117);
    tbl[5]  = v(1, 0, 0, 1, 32'hDEADBEEF,  0, 32'h10C, 32'h104, 32'h117);
    tbl[6]  = v(1, 0, 0, 0, 32'h0,         0, 32'h10C, 32'h104, 32'h117);
    tbl[7]  = v(0, 0, 0, 0, 32'h0,         0, 32'h10C, 32'h104, 32'h117);
    tbl[8]  = v(0, 0, 0, 1, 32'h113,       1, 32'h110, 32'h108, 32'h11B);
    tbl[9]  = v(0, 0, 0, 1, 32'h117,       1, 32'h114, 32'h10C, 32'h11F);
    tbl[10] = v(0, 0, 0, 0, 32'h0,         1, 32'h118, 32'h110, 32'h113);
    tbl[11] = v(0, 0, 0, 0, 32'h0,         1, 32'h118, 32'h114, 32'h117);
    tbl[12] = v(0, 0, 0, 1, 32'h11B,       1, 32'h118, 32'h114, 32'h0);
    tbl[13] = v(0, 0, 0, 0, 32'h0,         1, 32'h11C, 32'h118, 32'h11B);

    @(negedge CLK);
    @(negedge CLK);
    check_out("reset", 1'b0, 32'h100, 32'h100, 32'h0);
    RSTN = 1'b1;

    // Streaming, stall with FIFO fill, ack ignored in IDLE, drain.
    for (int i = 0; i < 14; i++) begin
      check_out($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].pc, tbl[i].inst);
      cyc(tbl[i].hlt, tbl[i].br, tbl[i].tgt, tbl[i].ack, tbl[i].rdata);
    end

    // 3-cycle ack latency: address stable, two bubbles per instruction.
    for (int k = 0; k < 3; k++) begin
      a = 32'h11C + 32'(4 * k);
      check($sformatf("lat%0d addr0", k), imem_addr, a);
      check($sformatf("lat%0d req0", k), {31'd0, imem_req}, 32'd1);
      cyc(0, 0, 0, 0, 0);
      check($sformatf("lat%0d addr1", k), imem_addr, a);
      check($sformatf("lat%0d bubble1", k), IF_ID_inst, 32'h0);
      cyc(0, 0, 0, 0, 0);
      check($sformatf("lat%0d addr2", k), imem_addr, a);
      check($sformatf("lat%0d bubble2", k), IF_ID_inst, 32'h0);
      cyc(0, 0, 0, 1, a | 32'h13);
      check($sformatf("lat%0d pc", k), IF_ID_pc, a);
      check($sformatf("lat%0d inst", k), IF_ID_inst, a | 32'h13);
    end

    // Branch while request to 0x128 is pending: drop it, then fetch 0x200.
    cyc(0, 1, 32'h200, 0, 0);
    check_out("drop0", 1'b1, 32'h128, 32'h124, 32'h0);
    cyc(0, 0, 0, 0, 0);
    check_out("drop1", 1'b1, 32'h128, 32'h124, 32'h0);
    cyc(0, 0, 0, 1, 32'h13B);
    check_out("drop_ack", 1'b1, 32'h200, 32'h124, 32'h0);
    cyc(0, 0, 0, 1, 32'h213);
    check_out("tgt0", 1'b1, 32'h204, 32'h200, 32'h213);
    cyc(0, 0, 0, 1, 32'h217);
    check_out("tgt1", 1'b1, 32'h208, 32'h204, 32'h217);

    // Fill the FIFO under HLT, then branch with HLT still high.
    cyc(1, 0, 0, 1, 32'h21B);
    check_out("fill1", 1'b1, 32'h20C, 32'h204, 32'h217);
    cyc(1, 0, 0, 1, 32'h21F);
    check_out("full", 1'b0, 32'h20C, 32'h204, 32'h217);
    cyc(1, 1, 32'h300, 0, 0);
    check_out("flush", 1'b1, 32'h300, 32'h204, 32'h0);
    cyc(0, 0, 0, 1, 32'h313);
    check_out("resume", 1'b1, 32'h304, 32'h300, 32'h313);
    cyc(0, 0, 0, 0, 0);
    check_out("emptied", 1'b1, 32'h304, 32'h300, 32'h0);

    // Branch in the same cycle as an ack: word discarded, target requested next cycle.
    cyc(0, 1, 32'h400, 1, 32'h317);
    check_out("br_ack", 1'b1, 32'h400, 32'h300, 32'h0);

    // Redirect to the top of the address space and wrap to 0.
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0);
    check_out("wrap_drop", 1'b1, 32'h400, 32'h300, 32'h0);
    cyc(0, 0, 0, 1, 32'h413);
    check_out("wrap_req", 1'b1, 32'hFFFF_FFFC, 32'h300, 32'h0);
    cyc(0, 0, 0, 1, 32'hFFFF_FFFF);
    check_out("wrap", 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    cyc(0, 0, 0, 1, 32'h13);
    check_out("wrap_next", 1'b1, 32'h4, 32'h0, 32'h13);

    // Asynchronous reset mid-request; a late ack after release is ignored.
    RSTN = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 32'h100, 32'h100, 32'h0);
    cyc(0, 0, 0, 1, 32'h17);
    RSTN = 1'b1;
    check_out("rst_idle", 1'b0, 32'h100, 32'h100, 32'h0);
    cyc(0, 0, 0, 1, 32'hBAD);
    check_out("rst_first", 1'b1, 32'h100, 32'h100, 32'h0);
    cyc(0, 0, 0, 0, 0);
    check_out("rst_no_late", 1'b1, 32'h100, 32'h100, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
